// File: rtl/generic_1clk_fifo_ctrl_if.sv
// Request/status bundle between a single-clock FIFO controller and its user logic.
// The controller takes the slave side; producer/consumer logic takes the master side.
interface generic_1clk_fifo_ctrl_if #(
  parameter int PTR_WIDTH = 8
);
  logic                 wr_op;
  logic                 rd_op;
  logic                 clr_err;
  logic [PTR_WIDTH:0]   afull_thr;
  logic [PTR_WIDTH:0]   aempty_thr;

  logic                 wr_en;
  logic [PTR_WIDTH-1:0] wr_addr;
  logic                 rd_en;
  logic [PTR_WIDTH-1:0] rd_addr;
  logic                 rd_data_valid;
  logic                 full;
  logic                 empty;
  logic                 afull;
  logic                 aempty;
  logic [PTR_WIDTH:0]   entry_used;
  logic                 err_wrfull;
  logic                 err_rdempty;

  modport master (
    output wr_op, rd_op, clr_err, afull_thr, aempty_thr,
    input  wr_en, wr_addr, rd_en, rd_addr, rd_data_valid, full, empty,
           afull, aempty, entry_used, err_wrfull, err_rdempty
  );

  modport slave (
    input  wr_op, rd_op, clr_err, afull_thr, aempty_thr,
    output wr_en, wr_addr, rd_en, rd_addr, rd_data_valid, full, empty,
           afull, aempty, entry_used, err_wrfull, err_rdempty
  );
endinterface

// File: rtl/generic_1clk_fifo_ctrl.sv
// Single-clock FIFO controller for a 1r1w memory of any depth 2..2^PTR_WIDTH.
// Define GENERIC_1CLK_FIFO_WMARK_EN to add the peak-occupancy output wmark.
module generic_1clk_fifo_ctrl #(
  parameter int PTR_WIDTH      = 8,
  parameter int NUM_OF_ENTRIES = 256
) (
  input  logic                 clk,
  input  logic                 rst,
  generic_1clk_fifo_ctrl_if.slave bus
`ifdef GENERIC_1CLK_FIFO_WMARK_EN
  ,
  output logic [PTR_WIDTH:0]   wmark
`endif
);

  localparam logic [PTR_WIDTH:0]   DEPTH    = (PTR_WIDTH+1)'(NUM_OF_ENTRIES);
  localparam logic [PTR_WIDTH-1:0] LAST_IDX = PTR_WIDTH'(NUM_OF_ENTRIES - 1);

  logic [PTR_WIDTH-1:0] wr_ptr;
  logic [PTR_WIDTH-1:0] rd_ptr;
  logic [PTR_WIDTH:0]   count;
  logic [PTR_WIDTH:0]   count_nxt;
  logic                 rd_valid_q;
  logic                 err_wrfull_q;
  logic                 err_rdempty_q;
  logic                 full;
  logic                 empty;
  logic                 wr_acc;
  logic                 rd_acc;

  // Wrap explicitly at the last entry so non-power-of-two depths work.
  function automatic logic [PTR_WIDTH-1:0] ptr_inc(input logic [PTR_WIDTH-1:0] p);
    return (p == LAST_IDX) ? '0 : p + PTR_WIDTH'(1);
  endfunction

  assign full   = (count == DEPTH);
  assign empty  = (count == '0);
  assign wr_acc = bus.wr_op && !full;
  assign rd_acc = bus.rd_op && !empty;

  // NOTE: always_comb assigns a default before the case so no path leaves
  // count_nxt unassigned, which would otherwise infer a latch.
  always_comb begin
    count_nxt = count;
    case ({wr_acc, rd_acc})
      2'b10:   count_nxt = count + (PTR_WIDTH+1)'(1);
      2'b01:   count_nxt = count - (PTR_WIDTH+1)'(1);
      default: count_nxt = count;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      count         <= '0;
      rd_valid_q    <= 1'b0;
      err_wrfull_q  <= 1'b0;
      err_rdempty_q <= 1'b0;
    end else begin
      if (wr_acc) wr_ptr <= ptr_inc(wr_ptr);
      if (rd_acc) rd_ptr <= ptr_inc(rd_ptr);
      count      <= count_nxt;
      rd_valid_q <= rd_acc;
      // A new error in the clearing cycle must survive the clear.
      err_wrfull_q  <= (bus.wr_op && full)  || (err_wrfull_q  && !bus.clr_err);
      err_rdempty_q <= (bus.rd_op && empty) || (err_rdempty_q && !bus.clr_err);
    end
  end

`ifdef GENERIC_1CLK_FIFO_WMARK_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      wmark <= '0;
    end else if (bus.clr_err) begin
      wmark <= count;
    end else if (count_nxt > wmark) begin
      wmark <= count_nxt;
    end
  end
`endif

  assign bus.wr_en         = wr_acc;
  assign bus.rd_en         = rd_acc;
  assign bus.wr_addr       = wr_ptr;
  assign bus.rd_addr       = rd_ptr;
  assign bus.rd_data_valid = rd_valid_q;
  assign bus.full          = full;
  assign bus.empty         = empty;
  assign bus.afull         = (count >= bus.afull_thr);
  assign bus.aempty        = (count <= bus.aempty_thr);
  assign bus.entry_used    = count;
  assign bus.err_wrfull    = err_wrfull_q;
  assign bus.err_rdempty   = err_rdempty_q;

endmodule

// File: tb/tb_generic_1clk_fifo_ctrl.sv
// Randomized and directed bench for generic_1clk_fifo_ctrl (PTR_WIDTH=3, depth 6)
// against a queue-based reference model of stored addresses.
module tb_generic_1clk_fifo_ctrl;

  localparam int PW    = 3;
  localparam int DEPTH = 6;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  generic_1clk_fifo_ctrl_if #(.PTR_WIDTH(PW)) bus ();

`ifdef GENERIC_1CLK_FIFO_WMARK_EN
  logic [PW:0] wmark;
`endif

  generic_1clk_fifo_ctrl #(.PTR_WIDTH(PW), .NUM_OF_ENTRIES(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
`ifdef GENERIC_1CLK_FIFO_WMARK_EN
    ,
    .wmark (wmark)
`endif
  );

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: queue of addresses currently holding data, plus the
  // next write slot; occupancy is simply the queue length.
  int q[$];
  int m_wi;
  bit m_rdv, m_ewf, m_erd;
`ifdef GENERIC_1CLK_FIFO_WMARK_EN
  int m_wm;
`endif

  bit c_w, c_r, c_clr, c_rst;
  bit e_wen, e_ren;

  task automatic model_reset();
    q.delete();
    m_wi  = 0;
    m_rdv = 0;
    m_ewf = 0;
    m_erd = 0;
`ifdef GENERIC_1CLK_FIFO_WMARK_EN
    m_wm = 0;
`endif
  endtask

  // Apply inputs for one cycle and compare all outputs before the edge.
  task automatic drive(input bit r, input bit w, input bit rd, input bit clr);
    int exp_ra;
    bit mf, me;
    c_rst = r; c_w = w; c_r = rd; c_clr = clr;
    rst = r; bus.wr_op = w; bus.rd_op = rd; bus.clr_err = clr;
    #1;
    mf     = (q.size() == DEPTH);
    me     = (q.size() == 0);
    e_wen  = w && !mf;
    e_ren  = rd && !me;
    exp_ra = me ? m_wi : q[0];
    n_cmp += 12;
    if (bus.wr_en !== e_wen) begin n_err++; $display("FAIL wr_en got=%b exp=%b t=%0t", bus.wr_en, e_wen, $time); end
    if (bus.rd_en !== e_ren) begin n_err++; $display("FAIL rd_en got=%b exp=%b t=%0t", bus.rd_en, e_ren, $time); end
    if (bus.wr_addr !== PW'(m_wi)) begin n_err++; $display("FAIL wr_addr got=%0d exp=%0d t=%0t", bus.wr_addr, m_wi, $time); end
    if (bus.rd_addr !== PW'(exp_ra)) begin n_err++; $display("FAIL rd_addr got=%0d exp=%0d t=%0t", bus.rd_addr, exp_ra, $time); end
    if (bus.full !== mf) begin n_err++; $display("FAIL full got=%b exp=%b t=%0t", bus.full, mf, $time); end
    if (bus.empty !== me) begin n_err++; $display("FAIL empty got=%b exp=%b t=%0t", bus.empty, me, $time); end
    if (bus.entry_used !== (PW+1)'(q.size())) begin n_err++; $display("FAIL entry_used got=%0d exp=%0d t=%0t", bus.entry_used, q.size(), $time); end
    if (bus.afull !== (q.size() >= int'(bus.afull_thr))) begin n_err++; $display("FAIL afull got=%b cnt=%0d thr=%0d t=%0t", bus.afull, q.size(), bus.afull_thr, $time); end
    if (bus.aempty !== (q.size() <= int'(bus.aempty_thr))) begin n_err++; $display("FAIL aempty got=%b cnt=%0d thr=%0d t=%0t", bus.aempty, q.size(), bus.aempty_thr, $time); end
    if (bus.rd_data_valid !== m_rdv) begin n_err++; $display("FAIL rd_data_valid got=%b exp=%b t=%0t", bus.rd_data_valid, m_rdv, $time); end
    if (bus.err_wrfull !== m_ewf) begin n_err++; $display("FAIL err_wrfull got=%b exp=%b t=%0t", bus.err_wrfull, m_ewf, $time); end
    if (bus.err_rdempty !== m_erd) begin n_err++; $display("FAIL err_rdempty got=%b exp=%b t=%0t", bus.err_rdempty, m_erd, $time); end
`ifdef GENERIC_1CLK_FIFO_WMARK_EN
    n_cmp++;
    if (wmark !== (PW+1)'(m_wm)) begin n_err++; $display("FAIL wmark got=%0d exp=%0d t=%0t", wmark, m_wm, $time); end
`endif
  endtask

  // Clock edge plus model update from the inputs applied by drive().
  task automatic tick();
    bit mf, me;
    int old;
    mf  = (q.size() == DEPTH);
    me  = (q.size() == 0);
    old = q.size();
    @(posedge clk);
    if (c_rst) begin
      model_reset();
    end else begin
      if (e_ren) void'(q.pop_front());
      if (e_wen) begin q.push_back(m_wi); m_wi = (m_wi + 1) % DEPTH; end
      m_rdv = e_ren;
      m_ewf = (c_w && mf) || (m_ewf && !c_clr);
      m_erd = (c_r && me) || (m_erd && !c_clr);
`ifdef GENERIC_1CLK_FIFO_WMARK_EN
      if (c_clr) m_wm = old;
      else if (q.size() > m_wm) m_wm = q.size();
`endif
    end
    #1;
  endtask

  task automatic cyc(input bit r, input bit w, input bit rd, input bit clr);
    drive(r, w, rd, clr);
    tick();
  endtask

  task automatic set_level(input int n);
    cyc(1, 0, 0, 0);
    for (int i = 0; i < n; i++) cyc(0, 1, 0, 0);
  endtask

  task automatic test_reset();
    rst = 1'b1; bus.wr_op = 1'b1; bus.rd_op = 1'b1; bus.clr_err = 1'b0;
    bus.afull_thr = 4'd5; bus.aempty_thr = 4'd1;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    n_cmp += 6;
    if (bus.entry_used !== 4'd0) begin n_err++; $display("FAIL reset_entry_used got=%0d exp=0", bus.entry_used); end
    if (bus.empty !== 1'b1) begin n_err++; $display("FAIL reset_empty got=%b exp=1", bus.empty); end
    if (bus.full !== 1'b0) begin n_err++; $display("FAIL reset_full got=%b exp=0", bus.full); end
    if (bus.rd_data_valid !== 1'b0) begin n_err++; $display("FAIL reset_rdv got=%b exp=0", bus.rd_data_valid); end
    if (bus.aempty !== 1'b1 || bus.afull !== 1'b0) begin n_err++; $display("FAIL reset_aflags got=%b%b exp=10", bus.aempty, bus.afull); end
    if (bus.err_wrfull !== 1'b0 || bus.err_rdempty !== 1'b0) begin n_err++; $display("FAIL reset_err got=%b%b exp=00", bus.err_wrfull, bus.err_rdempty); end
    cyc(1, 0, 0, 0);
  endtask

  task automatic test_fill();
    set_level(0);
    for (int i = 0; i < DEPTH; i++) begin
      n_cmp++;
      if (bus.wr_addr !== PW'(i)) begin n_err++; $display("FAIL fill_wr_addr got=%0d exp=%0d", bus.wr_addr, i); end
      cyc(0, 1, 0, 0);
      if (i == 0) begin n_cmp++; if (bus.aempty !== 1'b1) begin n_err++; $display("FAIL fill_aempty1 got=%b exp=1", bus.aempty); end end
      if (i == 1) begin n_cmp++; if (bus.aempty !== 1'b0) begin n_err++; $display("FAIL fill_aempty2 got=%b exp=0", bus.aempty); end end
      if (i == 3) begin n_cmp++; if (bus.afull !== 1'b0) begin n_err++; $display("FAIL fill_afull4 got=%b exp=0", bus.afull); end end
      if (i == 4) begin n_cmp++; if (bus.afull !== 1'b1) begin n_err++; $display("FAIL fill_afull5 got=%b exp=1", bus.afull); end end
    end
    n_cmp++;
    if (bus.full !== 1'b1 || bus.entry_used !== 4'd6) begin n_err++; $display("FAIL fill_full got=%b/%0d exp=1/6", bus.full, bus.entry_used); end
  endtask

  task automatic test_wrap();
    for (int i = 0; i < DEPTH; i++) begin
      n_cmp++;
      if (bus.rd_addr !== PW'(i)) begin n_err++; $display("FAIL wrap_rd_addr got=%0d exp=%0d", bus.rd_addr, i); end
      cyc(0, 0, 1, 0);
      n_cmp++;
      if (bus.rd_data_valid !== 1'b1) begin n_err++; $display("FAIL wrap_rdv got=%b exp=1", bus.rd_data_valid); end
    end
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if (bus.wr_addr !== PW'(i)) begin n_err++; $display("FAIL wrap_wr_addr got=%0d exp=%0d", bus.wr_addr, i); end
      cyc(0, 1, 0, 0);
    end
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if (bus.rd_addr !== PW'(i)) begin n_err++; $display("FAIL wrap_rd_addr2 got=%0d exp=%0d", bus.rd_addr, i); end
      cyc(0, 0, 1, 0);
    end
    cyc(0, 0, 0, 0);
    n_cmp++;
    if (bus.empty !== 1'b1 || bus.rd_data_valid !== 1'b0) begin n_err++; $display("FAIL wrap_end got=%b/%b exp=1/0", bus.empty, bus.rd_data_valid); end
  endtask

  task automatic test_simul_edges();
    set_level(DEPTH);
    drive(0, 1, 1, 0);
    n_cmp++;
    if (bus.rd_en !== 1'b1 || bus.wr_en !== 1'b0) begin n_err++; $display("FAIL full_both_en got=rd%b/wr%b exp=rd1/wr0", bus.rd_en, bus.wr_en); end
    tick();
    n_cmp++;
    if (bus.entry_used !== 4'd5 || bus.err_wrfull !== 1'b1) begin n_err++; $display("FAIL full_both_after got=%0d/%b exp=5/1", bus.entry_used, bus.err_wrfull); end
    set_level(0);
    drive(0, 1, 1, 0);
    n_cmp++;
    if (bus.wr_en !== 1'b1 || bus.rd_en !== 1'b0) begin n_err++; $display("FAIL empty_both_en got=wr%b/rd%b exp=wr1/rd0", bus.wr_en, bus.rd_en); end
    tick();
    n_cmp++;
    if (bus.entry_used !== 4'd1 || bus.err_rdempty !== 1'b1) begin n_err++; $display("FAIL empty_both_after got=%0d/%b exp=1/1", bus.entry_used, bus.err_rdempty); end
  endtask

  task automatic test_simul_mid();
    set_level(3);
    drive(0, 1, 1, 0);
    n_cmp++;
    if (bus.wr_en !== 1'b1 || bus.rd_en !== 1'b1) begin n_err++; $display("FAIL mid_both_en got=%b%b exp=11", bus.wr_en, bus.rd_en); end
    tick();
    n_cmp++;
    if (bus.entry_used !== 4'd3 || bus.wr_addr !== 3'd4 || bus.rd_addr !== 3'd1) begin
      n_err++; $display("FAIL mid_both_after got=cnt%0d/wa%0d/ra%0d exp=cnt3/wa4/ra1", bus.entry_used, bus.wr_addr, bus.rd_addr);
    end
  endtask

  task automatic test_sticky_clear();
    set_level(DEPTH);
    cyc(0, 1, 0, 0);
    cyc(0, 1, 0, 1);
    n_cmp++;
    if (bus.err_wrfull !== 1'b1) begin n_err++; $display("FAIL sticky_set_wins got=%b exp=1", bus.err_wrfull); end
    cyc(0, 0, 0, 1);
    n_cmp++;
    if (bus.err_wrfull !== 1'b0) begin n_err++; $display("FAIL sticky_clear got=%b exp=0", bus.err_wrfull); end
  endtask

  task automatic test_reset_mid();
    set_level(4);
    cyc(0, 0, 1, 0);
    cyc(0, 1, 0, 0);
    drive(1, 0, 1, 0);
    n_cmp++;
    if (bus.rd_en !== 1'b1) begin n_err++; $display("FAIL rstmid_rd_en got=%b exp=1", bus.rd_en); end
    tick();
    n_cmp++;
    if (bus.entry_used !== 4'd0 || bus.empty !== 1'b1 || bus.rd_data_valid !== 1'b0) begin
      n_err++; $display("FAIL rstmid got=cnt%0d/e%b/v%b exp=cnt0/e1/v0", bus.entry_used, bus.empty, bus.rd_data_valid);
    end
`ifdef GENERIC_1CLK_FIFO_WMARK_EN
    n_cmp++;
    if (wmark !== 4'd0) begin n_err++; $display("FAIL rstmid_wmark got=%0d exp=0", wmark); end
`endif
  endtask

  task automatic test_afull_zero();
    set_level(0);
    bus.afull_thr = 4'd0;
    #1;
    n_cmp++;
    if (bus.afull !== 1'b1) begin n_err++; $display("FAIL afull_thr0 got=%b exp=1", bus.afull); end
    cyc(0, 0, 0, 0);
    bus.afull_thr = 4'd5;
  endtask

  task automatic test_random();
    int wp;
    set_level(0);
    for (int i = 0; i < 600; i++) begin
      wp = ((i / 75) % 2 == 0) ? 70 : 30;
      if (i % 50 == 0) begin
        bus.afull_thr  = (PW+1)'($urandom_range(0, 7));
        bus.aempty_thr = (PW+1)'($urandom_range(0, 7));
      end
      cyc(($urandom_range(0, 99) == 0),
          ($urandom_range(0, 99) < wp),
          ($urandom_range(0, 99) < (100 - wp)),
          ($urandom_range(0, 15) == 0));
    end
    bus.afull_thr  = 4'd5;
    bus.aempty_thr = 4'd1;
  endtask

  initial begin
    test_reset();
    test_fill();
    test_wrap();
    test_simul_edges();
    test_simul_mid();
    test_sticky_clear();
    test_reset_mid();
    test_afull_zero();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout reached at t=%0t", $time);
    $fatal(1, "timeout");
  end

endmodule
